instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage directly upstream of instruction decode: owns the PC register, issues word reads to
//  instruction memory over a req/rvalid handshake and presents {pc, instr} to decode with instr_valid.
//  Next PC is chosen when decode consumes the instruction: pc+4, branch target or jalr target.
//  Detects misaligned targets and memory timeouts; both are sticky and halt fetch until reset.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; must be 4-byte aligned
//  TIMEOUT   16             max cycles from imem_req to imem_rvalid before bus_err
//  CNT_W     5              width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset_if     in   1   synchronous, active-high reset
//  imem_req     out  1   read request, single-cycle pulse
//  imem_addr    out  32  word address, equals pc while a request is outstanding
//  imem_rvalid  in   1   read data valid, at most one per request
//  imem_rdata   in   32  instruction word
//  instr        out  32  instruction to decode, held stable while instr_valid
//  pc           out  32  address of instr; also the base decode adds the branch offset to
//  instr_valid  out  1   instr/pc valid
//  dec_ready    in   1   decode/execute consumes instr this cycle (commit)
//  pc_sel       in   2   00 pc+4, 01 branch_addr, 10 jalr_tgt, 11 reserved (treated as 00)
//  branch_addr  in   32  pc + sign-extended imm from decode
//  jalr_tgt     in   32  rs1+imm from ALU; bit0 is cleared before use
//  misalign_err out  1   sticky: selected target had bits[1:0] != 0
//  bus_err      out  1   sticky: imem_rvalid not seen within TIMEOUT cycles
// BEHAVIOUR
//  Reset: pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0, errors=0, cnt=0,
//   state=REQ. Reset overrides everything, including an in-flight rvalid, which is dropped.
//  FSM:
//   REQ  : imem_req=1 for exactly one cycle, cnt<=0 -> WAIT.
//   WAIT : cnt++ each cycle. On imem_rvalid: instr<=imem_rdata, instr_valid<=1 -> HOLD.
//          If cnt==TIMEOUT-1 without rvalid: bus_err<=1 -> HALT.
//   HOLD : instr_valid=1, instr and pc stable. On dec_ready: compute next PC, instr_valid<=0.
//          Aligned target: pc<=next -> REQ. Misaligned: misalign_err<=1, pc unchanged -> HALT.
//   HALT : instr_valid=0, no requests. Exit only via reset_if.
//  Next PC, evaluated only in the HOLD&&dec_ready cycle:
//   00/11 -> pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0)
//   01    -> branch_addr
//   10    -> {jalr_tgt[31:1],1'b0}
//   Alignment check is on bits[1:0] of the selected value after bit0 clearing.
//  Timing:
//   Latency from reset release to first instr_valid is 2 cycles plus memory latency
//   (REQ 1 cycle, WAIT >=1).
//   Throughput is one instruction per (2 + memory latency) cycles; no prefetch, no speculation.
//  Handshake errors:
//   dec_ready outside HOLD is ignored.
//   imem_rvalid outside WAIT is ignored (spurious).
//   pc_sel, branch_addr and jalr_tgt are sampled only in the commit cycle.
// STRUCTURE
//  Shared package rv_pkg:
//   PC_SEL_* encodings (PC_SEL_PLUS4=2'b00, PC_SEL_BRANCH=2'b01, PC_SEL_JALR=2'b10)
//   NOP_INSTR=32'h0000_0013
//   fetch state enum {REQ, WAIT, HOLD, HALT}
//  Sub-module: next_pc_sel (combinational): selects the next PC and flags misalignment.
//  FSM, counter and PC register stay in instr_fetch.
// TESTING
//  1. Reset, then rvalid 1 cycle after req with 0x00500093 and dec_ready=1
//     -> instr_valid at cycle 3, pc=0, next req at addr 4.
//  2. Commit with pc=0x10, pc_sel=01, branch_addr=0x40
//     -> next imem_addr=0x40; pc_sel=00 gives 0x14.
//  3. Commit with pc_sel=10, jalr_tgt=0x101 -> pc=0x100.
//     Commit with jalr_tgt=0x102 -> misalign_err=1, HALT, no further imem_req.
//  4. Hold rvalid low for 16 cycles after req -> bus_err=1 on cycle 16, instr_valid stays 0.
//     Then assert reset_if -> errors clear, pc=RESET_PC.
//  5. Keep dec_ready=0 for 5 cycles in HOLD -> instr and pc unchanged, no imem_req.
//     Spurious rvalid in HOLD is ignored.
//  6. Assert reset_if in the same cycle as rvalid in WAIT -> data dropped, instr=nop, state REQ.
//     Wrap case: pc=0xFFFF_FFFC with pc_sel=00 -> next pc=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings, reset NOP, fetch FSM states.
package rv_pkg;

  localparam logic [1:0]  PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0]  PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0]  PC_SEL_JALR   = 2'b10;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux with misalignment flag on the selected target.
module next_pc_sel
  import rv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jalr_tgt,
  output logic [31:0] next_pc,
  output logic        misalign
);

  // Select target; reserved encoding falls back to sequential fetch
  always_comb begin
    next_pc = pc + 32'd4;
    unique case (pc_sel)
      PC_SEL_BRANCH: next_pc = branch_addr;
      PC_SEL_JALR:   next_pc = {jalr_tgt[31:1], 1'b0};
      default:       next_pc = pc + 32'd4;
    endcase
    misalign = |next_pc[1:0];
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, single-outstanding imem read, hold-until-commit to decode.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset_if,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jalr_tgt,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      next_pc;
  logic             next_misalign;

  next_pc_sel u_next_pc_sel (
    .pc          (pc),
    .pc_sel      (pc_sel),
    .branch_addr (branch_addr),
    .jalr_tgt    (jalr_tgt),
    .next_pc     (next_pc),
    .misalign    (next_misalign)
  );

  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);

  // State register
  always_ff @(posedge clk) begin
    if (reset_if) state <= REQ;
    else          state <= state_nxt;
  end

  // Next-state and request strobe; request is masked while reset is held
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    unique case (state)
      REQ: begin
        imem_req  = !reset_if;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid)          state_nxt = HOLD;
        else if (cnt == CNT_LAST) state_nxt = HALT;
      end
      HOLD: begin
        if (dec_ready) state_nxt = next_misalign ? HALT : REQ;
      end
      default: state_nxt = HALT;
    endcase
  end

  // Datapath: timeout counter, captured instruction, PC and sticky errors
  always_ff @(posedge clk) begin
    if (reset_if) begin
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      cnt          <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      unique case (state)
        REQ: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (imem_rvalid)          instr   <= imem_rdata;
          else if (cnt == CNT_LAST) bus_err <= 1'b1;
        end
        HOLD: begin
          if (dec_ready) begin
            if (next_misalign) misalign_err <= 1'b1;
            else               pc           <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fetch timing, PC selection, sticky errors, reset override.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        dec_ready;
  logic [1:0]  pc_sel;
  logic [31:0] branch_addr;
  logic [31:0] jalr_tgt;
  logic        misalign_err;
  logic        bus_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16),
    .CNT_W    (5)
  ) dut (
    .clk          (clk),
    .reset_if     (reset_if),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .dec_ready    (dec_ready),
    .pc_sel       (pc_sel),
    .branch_addr  (branch_addr),
    .jalr_tgt     (jalr_tgt),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Hold reset for two edges and release it at a negedge (REQ cycle begins)
  task automatic do_reset();
    @(negedge clk);
    reset_if = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_if = 1'b0;
    #1;
  endtask

  // Wait (bounded) for a request, then answer it one cycle later
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
    for (int i = 0; i < 40; i++) begin
      if (imem_req) break;
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check_eq({tag, "_addr"}, imem_addr, addr);
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    #1;
  endtask

  // Present a commit for one cycle in HOLD
  task automatic commit(input logic [1:0] sel, input logic [31:0] br, input logic [31:0] jt);
    dec_ready   = 1'b1;
    pc_sel      = sel;
    branch_addr = br;
    jalr_tgt    = jt;
    @(negedge clk);
    dec_ready   = 1'b0;
    pc_sel      = 2'b00;
    branch_addr = 32'hDEAD_BEE0;
    jalr_tgt    = 32'hDEAD_BEE0;
    #1;
  endtask

  initial begin
    int unsigned reqs;
    reset_if    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    dec_ready   = 1'b0;
    pc_sel      = 2'b00;
    branch_addr = '0;
    jalr_tgt    = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);

    // 1: first fetch, instr_valid on cycle 3
    reset_if = 1'b0;
    #1;
    check_eq("t1_req_c1", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    check_eq("t1_req_c2", {31'd0, imem_req}, 32'd0);
    check_eq("t1_valid_c2", {31'd0, instr_valid}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    check_eq("t1_valid_c3", {31'd0, instr_valid}, 32'd1);
    check_eq("t1_instr", instr, 32'h0050_0093);
    check_eq("t1_pc", pc, 32'h0);
    commit(2'b00, '0, '0);
    check_eq("t1_next_req", {31'd0, imem_req}, 32'd1);
    check_eq("t1_next_addr", imem_addr, 32'h4);
    check_eq("t1_valid_off", {31'd0, instr_valid}, 32'd0);

    // 2: walk to 0x10, sequential then branch, reserved select
    serve("t2a", 32'h4, 32'h1);  commit(2'b00, '0, '0);
    serve("t2b", 32'h8, 32'h2);  commit(2'b00, '0, '0);
    serve("t2c", 32'hC, 32'h3);  commit(2'b00, '0, '0);
    serve("t2d", 32'h10, 32'h4);
    check_eq("t2_pc10", pc, 32'h10);
    commit(2'b00, 32'h40, '0);
    check_eq("t2_plus4", imem_addr, 32'h14);
    serve("t2e", 32'h14, 32'h5);
    commit(2'b01, 32'h40, '0);
    check_eq("t2_branch", imem_addr, 32'h40);
    serve("t2f", 32'h40, 32'h6);
    commit(2'b11, 32'h80, 32'h80);
    check_eq("t2_reserved", imem_addr, 32'h44);

    // 3: jalr clears bit0; misaligned jalr halts
    serve("t3a", 32'h44, 32'h7);
    commit(2'b10, '0, 32'h101);
    check_eq("t3_jalr", imem_addr, 32'h100);
    serve("t3b", 32'h100, 32'h8);
    commit(2'b10, '0, 32'h102);
    check_eq("t3_misalign", {31'd0, misalign_err}, 32'd1);
    check_eq("t3_pc_kept", pc, 32'h100);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req || instr_valid) reqs++;
      @(negedge clk);
    end
    check_eq("t3_halted", reqs, 32'd0);
    do_reset();
    check_eq("t3_rst_clear", {31'd0, misalign_err}, 32'd0);

    // 4: timeout after 16 WAIT cycles
    check_eq("t4_req", {31'd0, imem_req}, 32'd1);
    reqs = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (instr_valid) reqs++;
    end
    check_eq("t4_no_err_yet", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    check_eq("t4_bus_err", {31'd0, bus_err}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (imem_req || instr_valid) reqs++;
      @(negedge clk);
    end
    check_eq("t4_halted", reqs, 32'd0);
    do_reset();
    check_eq("t4_rst_clear", {31'd0, bus_err}, 32'd0);
    check_eq("t4_rst_pc", pc, 32'h0);

    // 5: stall in HOLD, spurious rvalid ignored
    serve("t5", 32'h0, 32'hCAFE_0013);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (imem_req || !instr_valid || instr !== 32'hCAFE_0013 || pc !== 32'h0) reqs++;
    end
    check_eq("t5_stall", reqs, 32'd0);
    check_eq("t5_instr", instr, 32'hCAFE_0013);
    commit(2'b00, '0, '0);
    check_eq("t5_resume", imem_addr, 32'h4);

    // 6: reset coincident with rvalid drops data
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0BAD;
    reset_if    = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check_eq("t6_instr_nop", instr, NOP);
    check_eq("t6_valid", {31'd0, instr_valid}, 32'd0);
    reset_if = 1'b0;
    #1;
    check_eq("t6_req", {31'd0, imem_req}, 32'd1);
    serve("t6a", 32'h0, 32'h9);
    commit(2'b01, 32'hFFFF_FFFC, '0);
    serve("t6b", 32'hFFFF_FFFC, 32'hA);
    check_eq("t6_pc_top", pc, 32'hFFFF_FFFC);
    commit(2'b00, '0, '0);
    check_eq("t6_wrap", imem_addr, 32'h0);
    check_eq("t6_wrap_err", {31'd0, misalign_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
